// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment driver for the clock: per-frame input shadowing,
// tens/ones split, digit scan, separator decimal points and set-mode group blinking.
module clock_display_scan #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       _CR,
    input  logic [7:0] show_hour,
    input  logic [7:0] show_min,
    input  logic [7:0] show_sec,
    input  logic [2:0] blink_sel,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int STEP_CYC = CLK_HZ / SCAN_HZ;
    localparam int HALF_CYC = CLK_HZ / (2 * BLINK_HZ);
    localparam int STEP_W   = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int HALF_W   = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_CYC - 1);

    logic [STEP_W-1:0] scan_cnt_reg;
    logic [HALF_W-1:0] blink_cnt_reg;
    logic [2:0]        index_reg;
    logic              blink_phase_reg;
    logic              active_reg;
    logic [7:0]        hour_reg;
    logic [7:0]        min_reg;
    logic [7:0]        sec_reg;
    logic [5:0]        an_reg;
    logic [6:0]        seg_reg;
    logic              dp_reg;

    logic              scan_tick;
    logic              blink_wrap;
    logic [7:0]        group_val;
    logic [7:0]        digit_val;
    logic [6:0]        seg_next;
    logic              dp_next;
    logic [5:0]        an_next;
    logic [2:0]        blank_grp;

    assign scan_tick  = (scan_cnt_reg == STEP_LAST);
    assign blink_wrap = (blink_cnt_reg == HALF_LAST);
    assign blank_grp  = blink_sel & {3{blink_phase_reg}};

    function automatic logic [6:0] seg_decode(input logic [7:0] d);
        case (d)
            8'd0:    seg_decode = 7'b1000000;
            8'd1:    seg_decode = 7'b1111001;
            8'd2:    seg_decode = 7'b0100100;
            8'd3:    seg_decode = 7'b0110000;
            8'd4:    seg_decode = 7'b0011001;
            8'd5:    seg_decode = 7'b0010010;
            8'd6:    seg_decode = 7'b0000010;
            8'd7:    seg_decode = 7'b1111000;
            8'd8:    seg_decode = 7'b0000000;
            8'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        group_val = sec_reg;
        case (index_reg)
            3'd2, 3'd3: group_val = min_reg;
            3'd4, 3'd5: group_val = hour_reg;
            default:    group_val = sec_reg;
        endcase
        // Odd indices are the tens digit of their group.
        digit_val = index_reg[0] ? (group_val / 8'd10) : (group_val % 8'd10);
        if (group_val > 8'd99) begin
            seg_next = 7'b0111111;
        end else begin
            seg_next = seg_decode(digit_val);
        end
        dp_next = ~((index_reg == 3'd2) || (index_reg == 3'd4));
    end

    // A digit is lit only when selected and its group is not in the blanked blink phase.
    for (genvar gi = 0; gi < 6; gi++) begin : g_anode
        assign an_next[gi] = (index_reg != 3'(gi)) || blank_grp[gi/2];
    end

    always_ff @(posedge clk or negedge _CR) begin
        if (!_CR) begin
            scan_cnt_reg    <= '0;
            blink_cnt_reg   <= '0;
            index_reg       <= 3'd0;
            blink_phase_reg <= 1'b0;
            active_reg      <= 1'b0;
            hour_reg        <= 8'd0;
            min_reg         <= 8'd0;
            sec_reg         <= 8'd0;
            an_reg          <= 6'b111111;
            seg_reg         <= 7'b1111111;
            dp_reg          <= 1'b1;
        end else begin
            scan_cnt_reg  <= scan_tick ? '0 : scan_cnt_reg + 1'b1;
            blink_cnt_reg <= blink_wrap ? '0 : blink_cnt_reg + 1'b1;
            if (blink_wrap) begin
                blink_phase_reg <= ~blink_phase_reg;
            end
            if (scan_tick) begin
                active_reg <= 1'b1;
                if (index_reg == 3'd5) begin
                    index_reg <= 3'd0;
                    hour_reg  <= show_hour;
                    min_reg   <= show_min;
                    sec_reg   <= show_sec;
                end else begin
                    index_reg <= index_reg + 3'd1;
                end
            end
            // Outputs stay blank until the first step has elapsed after reset.
            if (active_reg) begin
                an_reg  <= an_next;
                seg_reg <= seg_next;
                dp_reg  <= dp_next;
            end
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;
    assign dp  = dp_reg;

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan: 10 cycles per digit step, 100 cycles per blink phase.
module tb_clock_display_scan;

    typedef struct {
        int         edge_no;
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    logic       clk;
    logic       _CR;
    logic [7:0] show_hour;
    logic [7:0] show_min;
    logic [7:0] show_sec;
    logic [2:0] blink_sel;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks   = 0;
    int failures = 0;
    int edge_cnt;

    vec_t tbl_norm[6];
    vec_t tbl_oor[6];

    clock_display_scan #(
        .CLK_HZ  (1000),
        .SCAN_HZ (100),
        .BLINK_HZ(5)
    ) dut (
        .clk      (clk),
        ._CR      (_CR),
        .show_hour(show_hour),
        .show_min (show_min),
        .show_sec (show_sec),
        .blink_sel(blink_sel),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release; stable when read on the falling edge.
    always @(posedge clk or negedge _CR) begin
        if (!_CR) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    task automatic go_to(input int target);
        int guard = 0;
        while (edge_cnt < target) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) begin
                $display("FAIL go_to: edge_cnt=%0d required to reach %0d", edge_cnt, target);
                failures++;
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "wait bound expired");
            end
        end
    endtask

    task automatic check_out(input string name, input logic [5:0] ea,
                             input logic [6:0] es, input logic ed);
        checks++;
        if (an !== ea || seg !== es || dp !== ed) begin
            failures++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                     name, an, seg, dp, ea, es, ed);
        end else begin
            $display("check %s: an=%b seg=%b dp=%b ok", name, an, seg, dp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end else begin
            $display("check %s: %0d ok", name, got);
        end
    endtask

    initial begin
        int idx;
        int ph;
        int err_p0;
        int err_p1;
        int err_pat;
        int err_hot;
        int trans;
        int zeros;
        logic [5:0] exp_an;
        logic [5:0] prev_an;
        logic [5:0] snap_an;
        logic [6:0] snap_seg;
        logic       snap_dp;

        tbl_norm[0] = '{65,  6'b111110, 7'b1111000, 1'b1};
        tbl_norm[1] = '{75,  6'b111101, 7'b1000000, 1'b1};
        tbl_norm[2] = '{85,  6'b111011, 7'b0010000, 1'b0};
        tbl_norm[3] = '{95,  6'b110111, 7'b0010010, 1'b1};
        tbl_norm[4] = '{105, 6'b101111, 7'b0110000, 1'b0};
        tbl_norm[5] = '{115, 6'b011111, 7'b0100100, 1'b1};

        tbl_oor[0]  = '{125, 6'b111110, 7'b1111000, 1'b1};
        tbl_oor[1]  = '{135, 6'b111101, 7'b1000000, 1'b1};
        tbl_oor[2]  = '{145, 6'b111011, 7'b0010000, 1'b0};
        tbl_oor[3]  = '{155, 6'b110111, 7'b0010010, 1'b1};
        tbl_oor[4]  = '{165, 6'b101111, 7'b0111111, 1'b0};
        tbl_oor[5]  = '{175, 6'b011111, 7'b0111111, 1'b1};

        _CR       = 1'b0;
        show_hour = 8'd23;
        show_min  = 8'd59;
        show_sec  = 8'd7;
        blink_sel = 3'b000;

        repeat (2) @(negedge clk);
        check_out("reset_state", 6'b111111, 7'b1111111, 1'b1);
        _CR = 1'b1;

        go_to(10);
        check_out("blank_before_first_step", 6'b111111, 7'b1111111, 1'b1);
        go_to(11);
        check_out("first_digit1_zero", 6'b111101, 7'b1000000, 1'b1);

        for (int i = 0; i < 6; i++) begin
            go_to(tbl_norm[i].edge_no);
            check_out($sformatf("normal_digit%0d", i), tbl_norm[i].an, tbl_norm[i].seg, tbl_norm[i].dp);
        end

        go_to(118);
        show_hour = 8'd100;
        for (int i = 0; i < 6; i++) begin
            go_to(tbl_oor[i].edge_no);
            check_out($sformatf("out_of_range_digit%0d", i), tbl_oor[i].an, tbl_oor[i].seg, tbl_oor[i].dp);
        end

        go_to(181);
        show_hour = 8'd23;
        blink_sel = 3'b010;
        err_p0 = 0;
        err_p1 = 0;
        snap_an = '0; snap_seg = '0; snap_dp = 1'b0;
        for (int k = 201; k <= 400; k++) begin
            go_to(k);
            idx = ((k - 1) / 10) % 6;
            ph  = ((k - 1) / 100) % 2;
            exp_an = ~(6'b000001 << idx);
            if (ph == 1 && (idx == 2 || idx == 3)) exp_an = 6'b111111;
            if (an !== exp_an) begin
                if (ph == 1) err_p1++;
                else         err_p0++;
            end
            if (k == 325) begin
                snap_an = an; snap_seg = seg; snap_dp = dp;
            end
        end
        blink_sel = 3'b000;
        check_int("blink_phase0_scan_errors", err_p0, 0);
        check_int("blink_phase1_scan_errors", err_p1, 0);
        checks++;
        if (snap_an !== 6'b111111 || snap_seg !== 7'b0010000 || snap_dp !== 1'b0) begin
            failures++;
            $display("FAIL blink_seg_still_driven: got an=%b seg=%b dp=%b, required an=111111 seg=0010000 dp=0",
                     snap_an, snap_seg, snap_dp);
        end else begin
            $display("check blink_seg_still_driven: ok");
        end

        go_to(445);
        show_sec = 8'd8;
        go_to(485);
        check_out("sec8_after_frame_ones", 6'b111110, 7'b0000000, 1'b1);
        go_to(487);
        show_sec = 8'd42;
        go_to(495);
        check_out("mid_frame_change_held_tens", 6'b111101, 7'b1000000, 1'b1);
        go_to(545);
        check_out("sec42_next_frame_ones", 6'b111110, 7'b0100100, 1'b1);
        go_to(555);
        check_out("sec42_next_frame_tens", 6'b111101, 7'b0011001, 1'b1);

        go_to(600);
        prev_an = an;
        err_pat = 0;
        err_hot = 0;
        trans   = 0;
        for (int k = 601; k <= 720; k++) begin
            go_to(k);
            idx = ((k - 1) / 10) % 6;
            exp_an = ~(6'b000001 << idx);
            if (an !== exp_an) err_pat++;
            zeros = 0;
            for (int b = 0; b < 6; b++) if (an[b] == 1'b0) zeros++;
            if (zeros != 1) err_hot++;
            if (an !== prev_an) trans++;
            prev_an = an;
        end
        check_int("cadence_pattern_errors", err_pat, 0);
        check_int("cadence_onehot_errors", err_hot, 0);
        check_int("cadence_step_transitions", trans, 12);

        go_to(725);
        #2 _CR = 1'b0;
        #1 check_out("async_reset_blank", 6'b111111, 7'b1111111, 1'b1);
        @(negedge clk);
        _CR = 1'b1;
        go_to(10);
        check_out("rereset_blank_edge10", 6'b111111, 7'b1111111, 1'b1);
        go_to(11);
        check_out("rereset_restart_index1", 6'b111101, 7'b1000000, 1'b1);
        go_to(65);
        check_out("rereset_first_load", 6'b111110, 7'b0100100, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
